// File: rtl/key_debouncer.sv
// Key debouncer: 2-flop synchronizer feeding a four-state qualification FSM with registered outputs.
// Define KEY_REPEAT_EN to add hold-to-repeat pulses on key_press.
module key_debouncer #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY  = 16,
    parameter int unsigned REPEAT_PERIOD = 8
) (
    input  logic clk,
    input  logic clear_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic busy
);

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StPressed,
        StReleaseWait
    } state_e;

    localparam logic [7:0] CntLast = 8'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255 || REPEAT_DELAY < 1 || REPEAT_DELAY > 255 ||
        REPEAT_PERIOD < 1 || REPEAT_PERIOD > 255) begin : g_param_check
        $error("key_debouncer: parameter out of legal range");
    end

    logic       sync_meta_q, sync_q;
    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_inc;
    logic       accept_press, accept_release;
    logic       press_d, level_d, busy_d;

    // Saturating so a mis-set counter can never wrap back into the trigger value.
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        accept_press   = 1'b0;
        accept_release = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sync_q) begin
                    state_d = StPressWait;
                    cnt_d   = 8'd1;
                end else begin
                    cnt_d = '0;
                end
            end
            StPressWait: begin
                if (!sync_q) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d      = StPressed;
                    cnt_d        = '0;
                    accept_press = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StPressed: begin
                if (!sync_q) begin
                    state_d = StReleaseWait;
                    cnt_d   = 8'd1;
                end else begin
                    cnt_d = '0;
                end
            end
            StReleaseWait: begin
                if (sync_q) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d        = StIdle;
                    cnt_d          = '0;
                    accept_release = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        endcase
        level_d = (state_d == StPressed) || (state_d == StReleaseWait);
        busy_d  = (state_d == StPressWait) || (state_d == StReleaseWait);
    end

`ifdef KEY_REPEAT_EN
    logic [7:0] rep_q, rep_d, rep_inc, rep_target;
    logic       rep_armed_q, rep_armed_d;
    logic       rep_fire;

    // rep_armed_q marks that the first (long) repeat delay has already elapsed.
    assign rep_inc    = (rep_q == 8'hFF) ? rep_q : rep_q + 8'd1;
    assign rep_target = rep_armed_q ? 8'(REPEAT_PERIOD) : 8'(REPEAT_DELAY);

    always_comb begin
        rep_d       = rep_q;
        rep_armed_d = rep_armed_q;
        rep_fire    = 1'b0;
        unique case (state_q)
            StIdle, StPressWait: begin
                rep_d       = '0;
                rep_armed_d = 1'b0;
            end
            StPressed: begin
                if (rep_inc == rep_target) begin
                    rep_fire    = 1'b1;
                    rep_d       = '0;
                    rep_armed_d = 1'b1;
                end else begin
                    rep_d = rep_inc;
                end
            end
            StReleaseWait: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            rep_q       <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_q       <= rep_d;
            rep_armed_q <= rep_armed_d;
        end
    end

    assign press_d = accept_press | rep_fire;
`else
    assign press_d = accept_press;
`endif

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            busy        <= 1'b0;
        end else begin
            sync_meta_q <= key_raw;
            sync_q      <= sync_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_level   <= level_d;
            key_press   <= press_d;
            key_release <= accept_release;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer: directed scenarios plus random key activity compared
// against a run-length reference model. Define KEY_REPEAT_EN to build both sides with repeat.
module tb_key_debouncer;

    localparam int StableCycles = 4;
    localparam int RepeatDelay  = 16;
    localparam int RepeatPeriod = 8;
`ifdef KEY_REPEAT_EN
    localparam bit RepeatEn = 1'b1;
`else
    localparam bit RepeatEn = 1'b0;
`endif

    logic clk     = 1'b0;
    logic clear_n = 1'b0;
    logic key_raw = 1'b0;
    logic key_level, key_press, key_release, busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_debouncer #(
        .STABLE_CYCLES(StableCycles),
        .REPEAT_DELAY (RepeatDelay),
        .REPEAT_PERIOD(RepeatPeriod)
    ) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .key_raw    (key_raw),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .busy       (busy)
    );

    // Reference: the decision input is key_raw two edges late; the level flips once the run of
    // samples disagreeing with it reaches StableCycles. Repeats follow time held steadily pressed.
    logic [1:0] m_dly     = '0;
    logic       m_level   = 1'b0;
    logic       m_press   = 1'b0;
    logic       m_release = 1'b0;
    logic       m_busy    = 1'b0;
    int         m_run     = 0;
    int         m_hold    = 0;

    always @(posedge clk or negedge clear_n) begin : ref_model
        logic s;
        logic steady;
        if (!clear_n) begin
            m_dly     = '0;
            m_level   = 1'b0;
            m_press   = 1'b0;
            m_release = 1'b0;
            m_busy    = 1'b0;
            m_run     = 0;
            m_hold    = 0;
        end else begin
            s         = m_dly[1];
            m_dly     = {m_dly[0], key_raw};
            steady    = m_level && (m_run == 0);
            m_press   = 1'b0;
            m_release = 1'b0;
            m_run     = (s != m_level) ? m_run + 1 : 0;
            if (m_run == StableCycles) begin
                m_level = s;
                m_run   = 0;
                if (s) begin
                    m_press = 1'b1;
                    m_hold  = 0;
                end else begin
                    m_release = 1'b1;
                end
            end else if (steady && RepeatEn) begin
                m_hold++;
                if (m_hold == RepeatDelay ||
                    (m_hold > RepeatDelay && (m_hold - RepeatDelay) % RepeatPeriod == 0))
                    m_press = 1'b1;
            end
            m_busy = (m_run != 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        logic [3:0] obs;
        repeat (2) @(negedge clk);
        obs = {key_level, key_press, key_release, busy};
        checks++;
        if (obs !== 4'b0000) begin
            failures++;
            $display("FAIL reset_held: {level,press,release,busy} got %b expected 0000", obs);
        end
        clear_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            obs = {key_level, key_press, key_release, busy};
            checks++;
            if (obs !== 4'b0000) begin
                failures++;
                $display("FAIL reset_idle edge %0d: outputs got %b expected 0000", e, obs);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_single_press();
        logic [3:0] obs, exp;
        key_raw = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            obs = {key_level, key_press, key_release, busy};
            exp = {e >= 6, e == 6, 1'b0, e >= 3 && e <= 5};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL single_press edge %0d: {level,press,release,busy} got %b expected %b",
                         e, obs, exp);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_release();
        logic [3:0] obs, exp;
        key_raw = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            obs = {key_level, key_press, key_release, busy};
            exp = {e < 6, 1'b0, e == 6, e >= 3 && e <= 5};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL release edge %0d: {level,press,release,busy} got %b expected %b",
                         e, obs, exp);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_glitch();
        logic [1:0] obs;
        key_raw = 1'b1;
        repeat (3) @(negedge clk);
        key_raw = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            obs = {key_level, key_press};
            checks++;
            if (obs !== 2'b00) begin
                failures++;
                $display("FAIL high_glitch edge %0d: {level,press} got %b expected 00", e, obs);
            end
        end
        @(negedge clk);
        key_raw = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (key_level !== 1'b1) begin
            failures++;
            $display("FAIL glitch_setup: key_level got %b expected 1", key_level);
        end
        key_raw = 1'b0;
        repeat (3) @(negedge clk);
        key_raw = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            obs = {key_level, key_release};
            checks++;
            if (obs !== 2'b10) begin
                failures++;
                $display("FAIL low_glitch edge %0d: {level,release} got %b expected 10", e, obs);
            end
        end
        @(negedge clk);
        key_raw = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (key_level !== 1'b0) begin
            failures++;
            $display("FAIL glitch_cleanup: key_level got %b expected 0", key_level);
        end
    endtask

    task automatic test_bounce();
        logic pat [5];
        logic [1:0] obs, exp;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            key_raw = pat[i];
            @(posedge clk); #1;
            checks++;
            if (key_press !== 1'b0) begin
                failures++;
                $display("FAIL bounce step %0d: key_press got %b expected 0", i, key_press);
            end
            @(negedge clk);
        end
        key_raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            obs = {key_level, key_press};
            exp = {e >= 6, e == 6};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL bounce_settle edge %0d: {level,press} got %b expected %b",
                         e, obs, exp);
            end
            if (e >= 3 && e <= 6) begin
                checks++;
                if (busy !== (e != 6)) begin
                    failures++;
                    $display("FAIL bounce_busy edge %0d: busy got %b expected %b", e, busy, e != 6);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_clear_pressed();
        logic [3:0] obs;
        logic [2:0] obs3, exp3;
        repeat (4) @(negedge clk);
        #2 clear_n = 1'b0;
        #1;
        obs = {key_level, key_press, key_release, busy};
        checks++;
        if (obs !== 4'b0000) begin
            failures++;
            $display("FAIL clear_async: {level,press,release,busy} got %b expected 0000", obs);
        end
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            obs = {key_level, key_press, key_release, busy};
            checks++;
            if (obs !== 4'b0000) begin
                failures++;
                $display("FAIL clear_held edge %0d: outputs got %b expected 0000", e, obs);
            end
        end
        @(negedge clk);
        clear_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            obs3 = {key_level, key_press, key_release};
            exp3 = {e >= 6, e == 6, 1'b0};
            checks++;
            if (obs3 !== exp3) begin
                failures++;
                $display("FAIL clear_repress edge %0d: {level,press,release} got %b expected %b",
                         e, obs3, exp3);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_repeat();
        int got[$];
        int exp[$];
        int n;
        bit both;
        key_raw = 1'b0;
        repeat (10) @(negedge clk);
        key_raw = 1'b1;
        both = 1'b0;
        for (int e = 1; e <= 66; e++) begin
            @(posedge clk); #1;
            if (key_press === 1'b1) got.push_back(e - 6);
            if (key_press === 1'b1 && key_release === 1'b1) both = 1'b1;
        end
        exp.push_back(0);
        if (RepeatEn)
            for (int t = RepeatDelay; t <= 60; t += RepeatPeriod) exp.push_back(t);
        checks++;
        if (got.size() != exp.size()) begin
            failures++;
            $display("FAIL repeat_count: press pulses got %0d expected %0d", got.size(), exp.size());
        end
        n = (got.size() < exp.size()) ? got.size() : exp.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got[i] != exp[i]) begin
                failures++;
                $display("FAIL repeat_offset %0d: press at +%0d expected +%0d", i, got[i], exp[i]);
            end
        end
        checks++;
        if (both) begin
            failures++;
            $display("FAIL repeat_exclusive: press&release together got 1 expected 0");
        end
        @(negedge clk);
        key_raw = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_random();
        logic [3:0] obs, exp;
        int remaining;
        remaining = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (!clear_n) clear_n = 1'b1;
            else if ($urandom_range(0, 199) == 0) clear_n = 1'b0;
            if (remaining == 0) begin
                key_raw   = ~key_raw;
                remaining = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 45)
                                                        : $urandom_range(1, 8);
            end
            remaining--;
            @(posedge clk); #1;
            obs = {key_level, key_press, key_release, busy};
            exp = {m_level, m_press, m_release, m_busy};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL random cycle %0d: {level,press,release,busy} got %b expected %b",
                         c, obs, exp);
            end
            checks++;
            if (key_press === 1'b1 && key_release === 1'b1) begin
                failures++;
                $display("FAIL random_exclusive cycle %0d: press&release got 1 expected 0", c);
            end
        end
        @(negedge clk);
        clear_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_release();
        test_glitch();
        test_bounce();
        test_clear_pressed();
        test_repeat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
